// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side master for the ring-buffer FIFO. Issues single-word reads,
//   collects PACK_RATIO consecutive words into one wide word (lane 0 = oldest)
//   and presents it on a valid/ready stream.
//
// Parameters
//   DATA_WIDTH     width of one FIFO word
//   PACK_RATIO     FIFO words per output word (>= 2)
//   FLUSH_TIMEOUT  idle cycles before a partial word is flushed
//                  (only with FIFO_RD_PACK_FLUSH_EN)
//
// Ports
//   clk           clock, all logic on posedge
//   reset         synchronous, active-high reset
//   fifo_rd_en    read request to FIFO (forced low while reset=1)
//   fifo_rd_data  FIFO data, valid in the cycle after fifo_rd_en
//   fifo_rd_val   FIFO read-valid, only meaningful in the cycle after fifo_rd_en
//   out_data      packed word, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid     out_data/out_cnt valid
//   out_ready     consumer accepts when out_valid && out_ready
//   out_cnt       number of valid lanes in out_data
//
// Build option
//   FIFO_RD_PACK_FLUSH_EN  when defined, a partial accumulator is flushed
//                          after FLUSH_TIMEOUT cycles without a captured
//                          word; out_cnt then reports the partial lane count
//                          and unused upper lanes are zero. When undefined,
//                          partial words are held until completed.

module fifo_rd_packer #(
  parameter int DATA_WIDTH    = 8,
  parameter int PACK_RATIO    = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  output logic                                fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]               fifo_rd_data,
  input  logic                                fifo_rd_val,
  output logic [DATA_WIDTH*PACK_RATIO-1:0]    out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(PACK_RATIO+1)-1:0]     out_cnt
);

  localparam int            CW   = $clog2(PACK_RATIO + 1);
  localparam int            OW   = DATA_WIDTH * PACK_RATIO;
  localparam logic [CW-1:0] FULL = CW'(PACK_RATIO);

  if (PACK_RATIO < 2) begin : g_bad_ratio
    $error("fifo_rd_packer: PACK_RATIO must be at least 2");
  end
  if (FLUSH_TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_rd_packer: FLUSH_TIMEOUT must be at least 1");
  end

  logic [OW-1:0] acc_data;
  logic [CW-1:0] acc_cnt;
  logic          inflight;

  logic          capture;
  logic          out_free;
  logic          full_xfer;
  logic          transfer;
  logic          rd_block;
  logic [CW-1:0] acc_eff;
  logic [CW-1:0] wr_lane;
  logic [CW:0]   issue_sum;
  logic [OW-1:0] xfer_data;

  // The FIFO keeps rd_val high between reads, so it only counts when a read
  // was actually issued in the previous cycle.
  assign capture   = inflight && fifo_rd_val;
  assign out_free  = !out_valid || out_ready;
  assign full_xfer = (acc_cnt == FULL) && out_free;

  // A response arriving alongside a transfer belongs to the next word.
  assign acc_eff = transfer ? '0 : acc_cnt;
  assign wr_lane = transfer ? '0 : acc_cnt;

  // Never have more reads in flight than free lanes, so every response
  // has a slot to land in.
  assign issue_sum  = {1'b0, acc_eff} + {{CW{1'b0}}, inflight};
  assign fifo_rd_en = !reset && !rd_block && (issue_sum < (CW + 1)'(PACK_RATIO));

`ifdef FIFO_RD_PACK_FLUSH_EN
  localparam int            IW       = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_TIMEOUT);

  logic [IW-1:0] idle_cnt;
  logic          timed_out;
  logic          flush_xfer;

  // Keep only the lanes that hold captured words; the rest read as zero.
  function automatic logic [OW-1:0] mask_lanes(input logic [OW-1:0] d,
                                               input logic [CW-1:0] n);
    logic [OW-1:0] m;
    m = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (CW'(i) < n) begin
        m[i*DATA_WIDTH +: DATA_WIDTH] = d[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return m;
  endfunction

  assign timed_out = (idle_cnt == IDLE_MAX);
  // Wait for the last outstanding read to return before flushing so a late
  // response cannot land in an accumulator that has already been emptied.
  assign flush_xfer = timed_out && (acc_cnt != '0) && !inflight && out_free;
  assign transfer   = full_xfer || flush_xfer;
  assign rd_block   = timed_out;
  assign xfer_data  = mask_lanes(acc_data, acc_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (capture || (acc_cnt == '0) || transfer) begin
      idle_cnt <= '0;
    end else if (!timed_out) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  assign transfer  = full_xfer;
  assign rd_block  = 1'b0;
  assign xfer_data = acc_data;
`endif

  // ---- stage p0 -> p1: read issue and response capture into the accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      acc_cnt  <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (transfer) begin
        acc_cnt <= capture ? CW'(1) : '0;
      end else if (capture) begin
        acc_cnt <= acc_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (capture && (wr_lane == CW'(i))) begin
        acc_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_data;
      end
    end
  end

  // ---- stage p1 -> p2: accumulator to output register
  // Output data is held whenever no transfer happens, which keeps it stable
  // under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= xfer_data;
      out_cnt   <= acc_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer (DATA_WIDTH=8, PACK_RATIO=4, FLUSH_TIMEOUT=16).
// A FIFO model answers reads one cycle after fifo_rd_en and holds rd_val high
// with junk data on non-response cycles. Expected packed words are queued as
// stimulus is issued; a monitor pops and compares on every accepted output.

module tb_fifo_rd_packer;

  logic        clk;
  logic        reset;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_val;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_cnt;

  fifo_rd_packer #(
    .DATA_WIDTH   (8),
    .PACK_RATIO   (4),
    .FLUSH_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_val (fifo_rd_val),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_cnt     (out_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   fq[$];          // FIFO contents; -1 = answer with rd_val=0 once
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pops = 0;
  int   last_resp_cyc = 0;
  int   accept_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model
  logic req_s;
  int   w;
  always @(negedge clk) req_s = fifo_rd_en;

  initial begin
    fifo_rd_val  = 1'b1;
    fifo_rd_data = 8'hEE;
  end

  always @(posedge clk) begin
    #1;
    if (req_s === 1'b1) begin
      if (fq.size() > 0) begin
        w = fq.pop_front();
        if (w < 0) begin
          fifo_rd_val  = 1'b0;
          fifo_rd_data = 8'hEE;
        end else begin
          fifo_rd_val   = 1'b1;
          fifo_rd_data  = w[7:0];
          pops++;
          last_resp_cyc = cyc;
        end
      end else begin
        fifo_rd_val  = 1'b0;
        fifo_rd_data = 8'hEE;
      end
    end else begin
      fifo_rd_val  = 1'b1;
      fifo_rd_data = 8'hEE;
    end
  end

  // Output monitor / scoreboard
  exp_t        e;
  logic        stall_prev = 1'b0;
  logic [31:0] hold_data;
  logic [2:0]  hold_cnt;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (stall_prev && (out_valid === 1'b1)) begin
        checks++;
        if ((out_data !== hold_data) || (out_cnt !== hold_cnt)) begin
          failures++;
          $display("FAIL hold_stable actual=%h/%0d required=%h/%0d",
                   out_data, out_cnt, hold_data, hold_cnt);
        end
      end
      if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
        accept_cyc = cyc;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output actual=%h/%0d required=none",
                   out_data, out_cnt);
        end else begin
          e = sb.pop_front();
          if ((out_data !== e.data) || (out_cnt !== e.cnt)) begin
            failures++;
            $display("FAIL out_word actual=%h/%0d required=%h/%0d",
                     out_data, out_cnt, e.data, e.cnt);
          end
        end
      end
      stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
      hold_data  = out_data;
      hold_cnt   = out_cnt;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_sb(input string name, input int max);
    int n;
    n = 0;
    while ((sb.size() > 0) && (n < max)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d_pending required=0_pending", name, sb.size());
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [2:0] c);
    exp_t x;
    x.data = d;
    x.cnt  = c;
    sb.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int n;

    // 1: reset held with FIFO holding data
    reset     = 1'b1;
    out_ready = 1'b1;
    fq = {32'h11, 32'h22, 32'h33, 32'h44};
    push_exp(32'h44332211, 3'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_cnt", {29'd0, out_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rd_en_after_reset", {31'd0, fifo_rd_en}, 32'd1);

    // 2: basic pack and latency
    wait_sb("t2", 60);
    chk("t2_latency", accept_cyc - last_resp_cyc, 32'd2);
    repeat (2) @(negedge clk);
    chk("t2_single_pulse", {31'd0, out_valid}, 32'd0);

    // 3: empty responses between words, junk held on idle cycles
    @(posedge clk); #1;
    fq = {32'h11, -1, -1, 32'h22, 32'h33, 32'h44};
    push_exp(32'h44332211, 3'd4);
    wait_sb("t3", 60);

    // 4: backpressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    p0 = pops;
    for (int v = 1; v <= 12; v++) fq.push_back(v);
    push_exp(32'h04030201, 3'd4);
    push_exp(32'h08070605, 3'd4);
    push_exp(32'h0C0B0A09, 3'd4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 14) chk("t4_rd_en_stalled", {31'd0, fifo_rd_en}, 32'd0);
    end
    chk("t4_reads_le8", {31'd0, (pops - p0) <= 8}, 32'd1);
    chk("t4_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_out_data", out_data, 32'h04030201);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_sb("t4", 80);

    // 5: partial accumulator discarded by reset
    @(posedge clk); #1;
    p0 = pops;
    fq = {32'hA1, 32'hA2};
    n = 0;
    while (((pops - p0) < 2) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    chk("t5_words_read", pops - p0, 32'd2);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    fq = {32'h01, 32'h02, 32'h03, 32'h04};
    push_exp(32'h04030201, 3'd4);
    wait_sb("t5", 60);
    repeat (4) @(negedge clk);
    chk("t5_no_extra", {31'd0, out_valid}, 32'd0);

    // 6: partial word after FIFO runs dry
    @(posedge clk); #1;
    fq = {32'h55, 32'h66};
`ifdef FIFO_RD_PACK_FLUSH_EN
    push_exp(32'h00006655, 3'd2);
    wait_sb("t6_flush", 80);
`else
    repeat (40) @(negedge clk);
    chk("t6_no_flush", {31'd0, out_valid}, 32'd0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side master for the team's ring-buffer FIFO. It drives the FIFO read port (rd_en, then rd_data/rd_val one cycle later), gathers PACK_RATIO consecutive words into one wide word, and presents that word on a valid/ready output stream. It sits between a narrow FIFO and a wide downstream consumer such as a bus writer or a DMA packer.

Parameters:
DATA_WIDTH, 8, width of one FIFO word.
PACK_RATIO, 4, FIFO words per output word (≥2).
FLUSH_TIMEOUT, 16, idle cycles before a partial-word flush (used only with FIFO_RD_PACK_FLUSH_EN).

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
fifo_rd_en  out  1  read request to FIFO.
fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid in the cycle after fifo_rd_en.
fifo_rd_val  in  1  FIFO read-valid, qualified only in the cycle after fifo_rd_en.
out_data  out  DATA_WIDTH*PACK_RATIO  packed word; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]; lane 0 = oldest word.
out_valid  out  1  out_data/out_cnt valid.
out_ready  in  1  consumer accepts when out_valid && out_ready.
out_cnt  out  $clog2(PACK_RATIO+1)  number of valid lanes.

Behaviour:
- Interface: reset is synchronous, active-high; the clock is clk.
- Reset: fifo_rd_en=0 (gated combinationally while reset=1), out_valid=0, out_data=0, out_cnt=0. Accumulator count acc_cnt=0, inflight=0, idle counter=0.
- State: accumulator (PACK_RATIO lanes, acc_cnt 0..PACK_RATIO), 1-bit inflight (= fifo_rd_en registered), and an output register (out_valid/out_data/out_cnt).
- Response capture: only in a cycle with inflight=1. If fifo_rd_val=1, write fifo_rd_data into lane acc_cnt and increment acc_cnt. If fifo_rd_val=0, the FIFO was empty: nothing is stored, no lane is skipped, and the read retries. fifo_rd_val and fifo_rd_data are ignored whenever inflight=0, because the FIFO holds rd_val high between reads.
- Transfer: when acc_cnt==PACK_RATIO and (out_valid==0 or out_ready==1):
  - the accumulator moves to the output register, with out_cnt=PACK_RATIO and out_valid=1;
  - acc_cnt becomes 0;
  - a response captured in the same cycle lands in lane 0 of the new accumulator.
- Issue rule: fifo_rd_en = !reset && (acc_eff + inflight < PACK_RATIO), where acc_eff=0 if a transfer occurs this cycle, else acc_cnt. At most one read is outstanding per lane slot, so a response always has a free lane.
- Throughput: with a non-empty FIFO and out_ready=1, PACK_RATIO reads per PACK_RATIO+1 cycles or better.
- Latency: the last word's response cycle is cycle t; acc_cnt==PACK_RATIO at t+1; out_valid rises at t+2.
- Output handshake: out_data and out_cnt stay stable while out_valid && !out_ready. out_valid clears after acceptance unless a new transfer happens in the same cycle.
- Backpressure: once the accumulator is full and out_valid is stalled, fifo_rd_en stays 0. At most 2*PACK_RATIO words are drained while the consumer stalls.
- Reset mid-operation: a partial accumulator and a pending out_valid are discarded. A FIFO response arriving in the first cycle after reset is ignored because inflight=0.
- Width rules: acc_cnt and out_cnt are $clog2(PACK_RATIO+1) bits. Lanes not written by a flush read as zero.

Optional Feature:
Macro FIFO_RD_PACK_FLUSH_EN.
- Defined: the idle counter increments each cycle with acc_cnt>0 and no word captured; it clears on a capture or when acc_cnt=0.
- When the counter reaches FLUSH_TIMEOUT, fifo_rd_en is suppressed.
- Once inflight=0 and (out_valid==0 or out_ready==1), the partial accumulator transfers with out_cnt=acc_cnt and upper lanes zero. acc_cnt and the counter then clear.
- Not defined: the idle counter is absent, partial words are held indefinitely, and out_cnt is always PACK_RATIO whenever out_valid=1.

Test Plan:
1. Reset held 3 cycles with FIFO holding data -> fifo_rd_en=0 and out_valid=0 throughout; first fifo_rd_en=1 in the cycle after reset falls.
2. FIFO preloaded 0x11,0x22,0x33,0x44, out_ready=1 -> single out_valid pulse with out_data=0x44332211, out_cnt=4, 2 cycles after the last response.
3. FIFO model returns rd_val=0 twice between 0x11 and 0x22, and holds rd_val=1 with junk 0xEE on non-response cycles -> out_data=0x44332211 with no skipped or junk lanes.
4. Words 0x01..0x0C, out_ready=0 for 20 cycles -> out_data=0x04030201 held stable, total reads accepted ≤8, fifo_rd_en=0 while stalled. Release -> 0x04030201, 0x08070605, 0x0C0B0A09 in order.
5. Two words 0xA1,0xA2 accepted, reset pulse, then 0x01..0x04 -> only output is 0x04030201.
6. With FIFO_RD_PACK_FLUSH_EN and FLUSH_TIMEOUT=16: words 0x55,0x66, then FIFO empty -> output 0x00006655 with out_cnt=2 after the timeout. Without the macro -> no output.
